// File: rtl/vram_arbiter_pkg.sv
// Shared constants and types for the VRAM arbiter.
// Covers the visible window size, the address/data widths, the CPU FSM states and the return tag.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ROW_W    = 9;
    localparam int COL_W    = 10;
    localparam int ADDR_W   = ROW_W + COL_W;
    localparam int DATA_W   = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } cpu_state_t;

    typedef enum logic {
        DISP = 1'b0,
        CPU  = 1'b1
    } ret_tag_t;

    // An address is {row, col}; anything outside the visible window is rejected.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr[ADDR_W-1:COL_W] < ROW_W'(V_ACTIVE)) &&
               (addr[COL_W-1:0] < COL_W'(H_ACTIVE));
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU-side request/acknowledge bus of the VRAM arbiter.
interface vram_arbiter_if;
    import vga_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );

endinterface

// File: rtl/vram_ret_pipe.sv
// Return-side pipeline: remembers who issued the previous cycle's VRAM access.
// It then steers the 1-cycle-late read data into the pixel register or the CPU read register.
module vram_ret_pipe
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_stb,
    input  logic              pix_vis,
    input  logic              cpu_rd,
    input  logic              cpu_rd_oor,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic [DATA_W-1:0] pix_rgb,
    output logic              pix_valid,
    output logic [DATA_W-1:0] cpu_rdata
);

    ret_tag_t tag_q;
    logic     stb_q;
    logic     vis_q;
    logic     oor_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= DISP;
            stb_q <= 1'b0;
            vis_q <= 1'b0;
            oor_q <= 1'b0;
        end else begin
            tag_q <= cpu_rd ? CPU : DISP;
            stb_q <= pix_stb;
            vis_q <= pix_vis;
            oor_q <= cpu_rd_oor;
        end
    end

    // A blank strobe still advances the pixel register, loading 0 / invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_rgb   <= '0;
            pix_valid <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            if (stb_q) begin
                if (vis_q && (tag_q == DISP)) begin
                    pix_rgb   <= vram_rdata;
                    pix_valid <= 1'b1;
                end else begin
                    pix_rgb   <= '0;
                    pix_valid <= 1'b0;
                end
            end
            if (tag_q == CPU) begin
                cpu_rdata <= oor_q ? '0 : vram_rdata;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority.
// CPU reads/writes use the cycles that are not display slots.
module vram_arbiter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              scan_active,
    input  logic [ROW_W-1:0]  scan_row,
    input  logic [COL_W-1:0]  scan_col,
    output logic [DATA_W-1:0] pix_rgb,
    output logic              pix_valid,
    vram_arbiter_if.slave     cpu,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    cpu_state_t state;
    cpu_state_t state_nxt;
    logic       disp_slot;
    logic       addr_ok;
    logic       rd_issue;

    assign disp_slot = pix_en & scan_active;
    assign addr_ok   = addr_in_range(cpu.cpu_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The port defaults to the scan address; the CPU takes it only from IDLE in a free cycle.
    always_comb begin
        state_nxt   = state;
        vram_addr   = {scan_row, scan_col};
        vram_we     = 1'b0;
        vram_wdata  = cpu.cpu_wdata;
        rd_issue    = 1'b0;
        cpu.cpu_ack = 1'b0;

        unique case (state)
            IDLE: begin
                if (cpu.cpu_req && !disp_slot) begin
                    vram_addr = cpu.cpu_addr;
                    if (cpu.cpu_we) begin
                        vram_we   = addr_ok;
                        state_nxt = ACK;
                    end else begin
                        rd_issue  = 1'b1;
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: state_nxt = ACK;
            ACK: begin
                cpu.cpu_ack = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (rst) begin
            vram_we = 1'b0;
        end
    end

    vram_ret_pipe u_ret_pipe (
        .clk        (clk),
        .rst        (rst),
        .pix_stb    (pix_en),
        .pix_vis    (disp_slot),
        .cpu_rd     (rd_issue),
        .cpu_rd_oor (!addr_ok),
        .vram_rdata (vram_rdata),
        .pix_rgb    (pix_rgb),
        .pix_valid  (pix_valid),
        .cpu_rdata  (cpu.cpu_rdata)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: randomized scan/CPU traffic plus directed scenarios.
// A queue-based scoreboard compares the DUT against a transaction-level reference model.
module tb_vram_arbiter;
    import vga_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pix_en = 1'b0;
    logic              scan_active = 1'b0;
    logic [ROW_W-1:0]  scan_row = '0;
    logic [COL_W-1:0]  scan_col = '0;
    logic [DATA_W-1:0] pix_rgb;
    logic              pix_valid;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_wdata;
    logic [DATA_W-1:0] vram_rdata;

    vram_arbiter_if cpu_bus ();

    vram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .scan_active (scan_active),
        .scan_row    (scan_row),
        .scan_col    (scan_col),
        .pix_rgb     (pix_rgb),
        .pix_valid   (pix_valid),
        .cpu         (cpu_bus),
        .vram_addr   (vram_addr),
        .vram_we     (vram_we),
        .vram_wdata  (vram_wdata),
        .vram_rdata  (vram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic              ok;
    } cpu_txn_t;

    typedef struct {
        int                tgt;
        logic              valid;
        logic [DATA_W-1:0] rgb;
    } pix_txn_t;

    cpu_txn_t          cpu_q[$];
    pix_txn_t          pix_q[$];
    logic [DATA_W-1:0] vram_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [int];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   wait_cnt = 0;
    int   ack_cyc = 0;
    bit   mon_en = 1'b0;
    bit   busy = 1'b0;
    bit   issued = 1'b0;
    logic ack_seen = 1'b0;
    logic [DATA_W-1:0] hold_rdata = '0;
    logic [DATA_W-1:0] hold_rgb = '0;
    logic              hold_valid = 1'b0;

    function automatic logic [DATA_W-1:0] pattern(input int a);
        int v;
        v = a * 37 ^ (a >>> 5);
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] mk_addr(input int row, input int col);
        return ADDR_W'(row * 1024 + col);
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pattern(int'(a));
    endfunction

    // Behavioural VRAM: synchronous read of the previous address, write on vram_we.
    always @(posedge clk) begin
        vram_rdata <= vram_mem[vram_addr];
        if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic applyStimulus(input logic pe, input logic act, input int row, input int col);
        pix_txn_t t;
        pix_en      = pe;
        scan_active = act;
        scan_row    = ROW_W'(row);
        scan_col    = COL_W'(col);
        if (pe && !rst) begin
            t.tgt   = cyc + 2;
            t.valid = act;
            t.rgb   = act ? ref_read(mk_addr(row, col)) : '0;
            pix_q.push_back(t);
        end
    endtask

    task automatic step(input logic pe, input logic act, input int row, input int col);
        @(negedge clk);
        ack_seen = cpu_bus.cpu_ack;
        @(posedge clk);
        #1;
        if (busy) begin
            wait_cnt++;
            if (ack_seen) begin
                busy            = 1'b0;
                cpu_bus.cpu_req = 1'b0;
            end else if (wait_cnt > 150) begin
                n_checks++;
                $display("[TB] FAIL cpu_timeout: no ack after %0d cycles, expected within 150", wait_cnt);
                busy            = 1'b0;
                cpu_bus.cpu_req = 1'b0;
                cpu_q.delete();
                issued          = 1'b0;
            end
        end
        applyStimulus(pe, act, row, col);
    endtask

    task automatic cpu_start(input logic we, input int row, input int col, input logic [DATA_W-1:0] wdata);
        cpu_txn_t t;
        t.we    = we;
        t.addr  = mk_addr(row, col);
        t.wdata = wdata;
        t.ok    = (row < V_ACTIVE) && (col < H_ACTIVE);
        t.rdata = (!we && t.ok) ? ref_read(t.addr) : '0;
        if (we && t.ok) ref_mem[int'(t.addr)] = wdata;
        cpu_q.push_back(t);
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_addr  = t.addr;
        cpu_bus.cpu_wdata = wdata;
        cpu_bus.cpu_req   = 1'b1;
        busy     = 1'b1;
        wait_cnt = 0;
    endtask

    task automatic wait_idle();
        while (busy) step(1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: the CPU issues in the first free cycle after its request; everything else follows.
    always @(negedge clk) begin
        logic disp;
        logic exp_we;
        logic exp_ack;
        if (mon_en) begin
            disp    = pix_en && scan_active;
            exp_we  = 1'b0;
            exp_ack = 1'b0;
            if (!rst) begin
                if (disp) checkOutput("disp_addr", vram_addr, mk_addr(scan_row, scan_col));
                if (cpu_q.size() > 0 && !issued && !disp) begin
                    issued  = 1'b1;
                    ack_cyc = cyc + (cpu_q[0].we ? 1 : 2);
                    checkOutput("cpu_issue_addr", vram_addr, cpu_q[0].addr);
                    if (cpu_q[0].we) begin
                        exp_we = cpu_q[0].ok;
                        if (cpu_q[0].ok) checkOutput("vram_wdata", vram_wdata, cpu_q[0].wdata);
                    end
                end
                exp_ack = (cpu_q.size() > 0) && issued && (cyc == ack_cyc);
            end
            checkOutput("vram_we", vram_we, exp_we);
            checkOutput("cpu_ack", cpu_bus.cpu_ack, exp_ack);
            if (exp_ack) begin
                if (!cpu_q[0].we) hold_rdata = cpu_q[0].rdata;
                void'(cpu_q.pop_front());
                issued = 1'b0;
            end
            checkOutput("cpu_rdata", cpu_bus.cpu_rdata, hold_rdata);
            if (pix_q.size() > 0 && pix_q[0].tgt == cyc) begin
                hold_rgb   = pix_q[0].rgb;
                hold_valid = pix_q[0].valid;
                void'(pix_q.pop_front());
            end
            checkOutput("pix_rgb", pix_rgb, hold_rgb);
            checkOutput("pix_valid", pix_valid, hold_valid);
            if (rst) begin
                cpu_q.delete();
                pix_q.delete();
                issued     = 1'b0;
                hold_rdata = '0;
                hold_rgb   = '0;
                hold_valid = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) vram_mem[i] = pattern(i);
        vram_mem[mk_addr(5, 10)]      = 12'hABC;
        ref_mem[int'(mk_addr(5, 10))] = 12'hABC;

        // Reset with a pending in-range write in a free cycle.
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_addr  = mk_addr(2, 3);
        cpu_bus.cpu_wdata = 12'h7FF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_vram_we", vram_we, 0);
        checkOutput("rst_cpu_ack", cpu_bus.cpu_ack, 0);
        checkOutput("rst_pix_rgb", pix_rgb, 0);
        checkOutput("rst_pix_valid", pix_valid, 0);
        checkOutput("rst_cpu_rdata", cpu_bus.cpu_rdata, 0);
        checkOutput("rst_fsm_idle", dut.state, IDLE);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        cpu_bus.cpu_req = 1'b0;
        mon_en          = 1'b1;

        $display("[TB] display fetch at {5,10}");
        step(1'b0, 1'b1, 5, 9);
        step(1'b1, 1'b1, 5, 10);
        step(1'b0, 1'b1, 5, 10);
        step(1'b0, 1'b1, 5, 10);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);

        $display("[TB] CPU write then read in blanking");
        cpu_start(1'b1, 2, 3, 12'h123);
        wait_idle();
        cpu_start(1'b0, 2, 3, '0);
        wait_idle();

        $display("[TB] contention with display slot");
        step(1'b1, 1'b1, 7, 20);
        cpu_start(1'b0, 450, 5, '0);
        step(1'b0, 1'b1, 7, 21);
        step(1'b1, 1'b1, 7, 21);
        step(1'b0, 1'b1, 7, 22);
        wait_idle();

        $display("[TB] out-of-range write and read");
        step(1'b0, 1'b0, 0, 0);
        cpu_start(1'b1, 10, 700, 12'h555);
        wait_idle();
        cpu_start(1'b0, 500, 5, '0);
        wait_idle();

        $display("[TB] request withdrawn during display slots");
        step(1'b1, 1'b1, 8, 30);
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_addr  = mk_addr(420, 1);
        cpu_bus.cpu_wdata = 12'hFFF;
        cpu_bus.cpu_req   = 1'b1;
        step(1'b1, 1'b1, 8, 31);
        cpu_bus.cpu_req   = 1'b0;
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);

        $display("[TB] reset during RD_WAIT");
        step(1'b0, 1'b0, 0, 0);
        cpu_start(1'b0, 450, 9, '0);
        step(1'b0, 1'b0, 0, 0);
        rst             = 1'b1;
        cpu_bus.cpu_req = 1'b0;
        busy            = 1'b0;
        step(1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 0, 0);
        cpu_start(1'b0, 2, 3, '0);
        wait_idle();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            int   mode;
            logic pe;
            logic act;
            int   row;
            int   col;
            mode = (i / 64) % 3;
            row  = int'($urandom_range(0, 399));
            col  = int'($urandom_range(0, 639));
            act  = ($urandom_range(0, 3) != 0);
            case (mode)
                0:       pe = (i % 2 == 0);
                1:       pe = ($urandom_range(0, 1) == 1);
                default: begin
                    pe  = 1'b1;
                    act = ((i % 50) < 40);
                end
            endcase
            step(pe, act, row, col);
            if (!busy && $urandom_range(0, 2) == 0) begin
                logic we;
                int   r;
                int   c;
                we = ($urandom_range(0, 1) == 1);
                r  = we ? int'($urandom_range(400, 479)) : int'($urandom_range(0, 479));
                c  = int'($urandom_range(0, 639));
                if ($urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 1) == 1) r = int'($urandom_range(480, 511));
                    else                           c = int'($urandom_range(640, 1023));
                end
                cpu_start(we, r, c, DATA_W'($urandom));
            end
        end
        wait_idle();
        repeat (3) step(1'b0, 1'b0, 0, 0);
        checkOutput("cpu_queue_drained", cpu_q.size(), 0);
        checkOutput("pix_queue_drained", pix_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates the single-port video RAM between the VGA scan fetch and a CPU read/write port. The display side is driven by the horizontal/vertical scan counters: row, column and active-window flag, plus a pixel enable. The display side has absolute priority and produces one pixel per pixel period during the active window. CPU accesses are served in every remaining cycle through a req/ack handshake. The block sits between the scan timing generator, the VRAM instance and the CPU bus bridge.

## Interface
- `ADDR_W`, 19, VRAM address width; address = {row[8:0], col[9:0]}
- `DATA_W`, 12, pixel width (RGB444)
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel-advance strobe from scan timing
- `scan_active`  in  1  scan is inside the 640x480 visible window
- `scan_row`  in  9  current visible row, 0..479
- `scan_col`  in  10  current visible column, 0..639
- `pix_rgb`  out  DATA_W  pixel to the DAC/RGB pins; 0 when blank
- `pix_valid`  out  1  `pix_rgb` corresponds to a fetched visible pixel
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  {row, col}
- `cpu_wdata`  in  DATA_W  write data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  DATA_W  read data; valid while `cpu_ack`=1, held afterwards
- `vram_addr`  out  ADDR_W  VRAM address (combinational from state and inputs)
- `vram_we`  out  1  VRAM write enable
- `vram_wdata`  out  DATA_W  VRAM write data
- `vram_rdata`  in  DATA_W  VRAM read data; 1-cycle latency from address

## Operation
- **Display slot.** Any cycle with `pix_en & scan_active`.
  - VRAM drives: `vram_addr={scan_row,scan_col}`, `vram_we=0`.
  - Return tag = DISP.
- **Blank fetch.** Any cycle with `pix_en & ~scan_active`.
  - Nothing is issued; the pixel pipeline carries the constant 0 with valid=0.
- **Free cycle.** Any cycle that is not a display slot. The CPU may issue only in a free cycle.
- **CPU FSM states.** IDLE, RD_WAIT, ACK.
  - **IDLE:** if `cpu_req` and the cycle is free, issue the access.
    - Write: `vram_we=1`, `vram_addr=cpu_addr`, `vram_wdata=cpu_wdata`; go to ACK.
    - Read: `vram_we=0`, `vram_addr=cpu_addr`, return tag = CPU; go to RD_WAIT.
    - If `cpu_req` is high in a display slot, stay in IDLE (stall).
  - **RD_WAIT:** capture `vram_rdata` into `cpu_rdata`; go to ACK. The VRAM port is free for a display slot in this cycle.
  - **ACK:** `cpu_ack=1`. `cpu_req` is ignored in this cycle; go to IDLE.
- **Address range check.** Out of range means `col>=640` or `row>=480`.
  - Out-of-range write: `vram_we` is forced to 0, but the write is still acked.
  - Out-of-range read: `cpu_rdata=0`, acked with read timing.
- **Return tagging.** A 1-bit return tag, registered each cycle, selects whether `vram_rdata` is routed to the pixel register or to `cpu_rdata`. Display and CPU returns can arrive back-to-back.
- **Requester rules.**
  - `cpu_addr`, `cpu_we` and `cpu_wdata` must stay stable from req rise until ack.
  - Dropping `cpu_req` while in IDLE withdraws the request with no side effect.
  - Dropping it after issue does not cancel the access; the ack still pulses.
- **Starvation bound.**
  - With `pix_en` at 1/2 duty, the CPU is guaranteed 1 free cycle in 2.
  - With `pix_en` tied high, the CPU is served only outside the active window, so the wait is bounded by one visible line.
- **Reset.**
  - `rst` forces IDLE and clears the tag pipe.
  - Output reset values: `pix_rgb=0`, `pix_valid=0`, `cpu_ack=0`, `cpu_rdata=0`.
  - `vram_we=0` during any cycle with `rst=1`.
  - An in-flight CPU access is dropped without ack; the requester re-issues it.

## Timing
- **Display.** A slot in cycle N gives `vram_rdata` in N+1 and `pix_rgb`/`pix_valid` in N+2 (registered).
  - Blank fetch: `pix_rgb=0`, `pix_valid=0` at the same N+2 latency.
  - `pix_rgb` holds its value between pixel strobes.
- **CPU write.** Issue in cycle N; `cpu_ack` in N+1.
  - Minimum spacing between writes: 2 cycles.
- **CPU read.** Issue in cycle N; `vram_rdata` in N+1; `cpu_ack` and `cpu_rdata` in N+2.
  - Minimum spacing between reads: 3 cycles.
- **Stall cost.** Each display slot that coincides with a pending request in IDLE adds exactly one cycle to the CPU latency.

## Structure
- Package `vga_pkg`:
  - `H_ACTIVE=640`, `V_ACTIVE=480`, `ADDR_W`, `DATA_W`
  - CPU FSM state enum {IDLE, RD_WAIT, ACK}
  - Return-tag enum {DISP, CPU}
- Sub-module `vram_ret_pipe`: tag register plus the data steering into the pixel register and `cpu_rdata`.
  - Keeps the latency alignment isolated from the arbitration FSM.

## Test plan
- **Reset.** Hold `rst` high 3 cycles with `cpu_req=1`.
  - Expect `vram_we=0`, `cpu_ack=0`, `pix_rgb=0`, `pix_valid=0`, FSM in IDLE.
- **Display fetch.** `scan_active=1`, `pix_en` toggling, row=5, col=10, VRAM word at {5,10}=0xABC.
  - Expect `vram_addr=0x0140A` in the strobe cycle and `pix_rgb=0xABC`, `pix_valid=1` two cycles later.
- **CPU write in blanking.** `scan_active=0`, write addr {2,3}, data 0x123.
  - Expect `vram_we=1` in the issue cycle and `cpu_ack` the next cycle.
  - A follow-up read of {2,3} returns 0x123 with ack 2 cycles after its issue.
- **Contention.** `cpu_req` (read) rises in a display-slot cycle.
  - Expect the issue 1 cycle later, pixel data and CPU data returned in consecutive cycles without cross-routing.
  - Expect exactly one ack.
- **Out of range.** Write to col=700, then read row=500.
  - Write: `vram_we` stays 0 and the write is acked.
  - Read: `cpu_rdata=0` and the read is acked.
- **Mid-read reset.** Assert `rst` in the RD_WAIT cycle.
  - Expect no `cpu_ack`, `cpu_rdata=0`, and normal service of the next request.
